// File: rtl/traffic_scheduler.sv
// rtl/traffic_scheduler.sv - four-lane round-robin traffic light scheduler
// Optional emergency preemption is compiled in when EMERGENCY_PREEMPT_EN is defined.
module traffic_scheduler #(
    parameter int SLOT = 5,
    parameter int LONG = 10,
    parameter int YEL  = 2,
    parameter int AR   = 1,
    parameter int TW   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:1] sensors,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic [4:1] emg_req,
`endif
    output logic [4:1] green,
    output logic [4:1] yellow,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;

    localparam logic [TW-1:0] SLOT_T = TW'(SLOT - 1);
    localparam logic [TW-1:0] LONG_T = TW'(LONG - 1);
    localparam logic [TW-1:0] YEL_T  = TW'(YEL - 1);
    localparam logic [TW-1:0] AR_T   = TW'(AR - 1);

    state_t          state, state_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [1:0]      lane, lane_nxt;   // index 0..3 stands for lane 1..4
    logic [1:0]      last, last_nxt;
    logic [3:0][1:0] demand;

    logic            arb_valid;
    logic [1:0]      arb_lane;
    logic [1:0]      arb_idx;
    logic [TW-1:0]   arb_dur;
    logic            grant_valid;
    logic [1:0]      grant_lane;
    logic [TW-1:0]   grant_dur;
    logic            hold_green;
    logic            preempt;

    assign demand = sensors;

    // Scan from the highest offset down so the nearest lane after 'last' wins.
    always_comb begin
        arb_valid = 1'b0;
        arb_lane  = last;
        arb_idx   = last;
        arb_dur   = SLOT_T;
        for (int i = 4; i >= 1; i--) begin
            arb_idx = last + 2'(i);
            if (demand[arb_idx] != 2'b00) begin
                arb_valid = 1'b1;
                arb_lane  = arb_idx;
                arb_dur   = (demand[arb_idx] == 2'b11) ? LONG_T : SLOT_T;
            end
        end
    end

`ifdef EMERGENCY_PREEMPT_EN
    logic       emg_any;
    logic [1:0] emg_lane;
    logic       pend, pend_nxt;
    logic [1:0] pend_lane, pend_lane_nxt;

    always_comb begin
        emg_any  = |emg_req;
        emg_lane = 2'd0;
        for (int i = 4; i >= 1; i--)
            if (emg_req[i]) emg_lane = 2'(i - 1);
    end

    assign hold_green = emg_req[3'(lane) + 3'd1];
    assign preempt    = emg_any && (emg_lane != lane);

    // A preempted lane's clearance must finish before E gets green, so remember E.
    always_comb begin
        pend_nxt      = pend;
        pend_lane_nxt = pend_lane;
        if (state == GREEN && preempt) begin
            pend_nxt      = 1'b1;
            pend_lane_nxt = emg_lane;
        end else if (state_nxt == GREEN && state != GREEN) begin
            pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend      <= 1'b0;
            pend_lane <= 2'd0;
        end else begin
            pend      <= pend_nxt;
            pend_lane <= pend_lane_nxt;
        end
    end

    always_comb begin
        grant_valid = arb_valid;
        grant_lane  = arb_lane;
        grant_dur   = arb_dur;
        if (pend) begin
            grant_valid = 1'b1;
            grant_lane  = pend_lane;
            grant_dur   = SLOT_T;
        end else if (emg_any) begin
            grant_valid = 1'b1;
            grant_lane  = emg_lane;
            grant_dur   = SLOT_T;
        end
    end
`else
    assign hold_green  = 1'b0;
    assign preempt     = 1'b0;
    assign grant_valid = arb_valid;
    assign grant_lane  = arb_lane;
    assign grant_dur   = arb_dur;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            timer <= '0;
            lane  <= 2'd3;
            last  <= 2'd3;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            lane  <= lane_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        lane_nxt  = lane;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nxt = GREEN;
                    timer_nxt = grant_dur;
                    lane_nxt  = grant_lane;
                    last_nxt  = grant_lane;
                end
            end
            GREEN: begin
                if (preempt || (timer == '0 && !hold_green)) begin
                    state_nxt = YELLOW;
                    timer_nxt = YEL_T;
                end else if (timer != '0) begin
                    timer_nxt = timer - TW'(1);
                end
            end
            YELLOW: begin
                if (timer == '0) begin
                    state_nxt = ALLRED;
                    timer_nxt = AR_T;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            ALLRED: begin
                if (timer != '0) begin
                    timer_nxt = timer - TW'(1);
                end else if (grant_valid) begin
                    state_nxt = GREEN;
                    timer_nxt = grant_dur;
                    lane_nxt  = grant_lane;
                    last_nxt  = grant_lane;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        green  = '0;
        yellow = '0;
        busy   = (state != IDLE);
        case (state)
            GREEN:   green  = 4'b0001 << lane;
            YELLOW:  yellow = 4'b0001 << lane;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_scheduler.sv
// tb/tb_traffic_scheduler.sv - table-driven bench for traffic_scheduler
module tb_traffic_scheduler;

    localparam int SLOT = 5;
    localparam int LONG = 10;
    localparam int YEL  = 2;
    localparam int AR   = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:1] sensors;
    logic [4:1] green;
    logic [4:1] yellow;
    logic       busy;
`ifdef EMERGENCY_PREEMPT_EN
    logic [4:1] emg_req;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] sens;
        int         cycles;
        logic [3:0] g;
        logic [3:0] y;
        logic       b;
    } vec_t;

    vec_t vecs[$];

    traffic_scheduler #(.SLOT(SLOT), .LONG(LONG), .YEL(YEL), .AR(AR), .TW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .sensors (sensors),
`ifdef EMERGENCY_PREEMPT_EN
        .emg_req (emg_req),
`endif
        .green   (green),
        .yellow  (yellow),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Lights must never show green and yellow together, and each is one-hot or zero.
    always @(negedge clk) begin
        n_cmp++;
        if (((|green) && (|yellow)) || !$onehot0(green) || !$onehot0(yellow)) begin
            n_fail++;
            $display("FAIL light_exclusive: green=%b yellow=%b required one-hot-or-zero, not both", green, yellow);
        end
    end

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: {green,yellow,busy} got %b_%b_%b required %b_%b_%b",
                     name, act[8:5], act[4:1], act[0], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    task automatic add(input logic [7:0] s, input int n, input logic [3:0] g,
                       input logic [3:0] y, input logic b);
        vec_t v;
        v.sens = s; v.cycles = n; v.g = g; v.y = y; v.b = b;
        vecs.push_back(v);
    endtask

    task automatic add_lane(input logic [7:0] s, input int ln, input int glen);
        logic [3:0] m;
        m = 4'(1 << (ln - 1));
        add(s, glen, m, 4'b0000, 1'b1);
        add(s, YEL, 4'b0000, m, 1'b1);
        add(s, AR, 4'b0000, 4'b0000, 1'b1);
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            sensors = vecs[i].sens;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                @(posedge clk);
                #1;
                check($sformatf("vec%0d_cyc%0d", i, c), {green, yellow, busy},
                      {vecs[i].g, vecs[i].y, vecs[i].b});
            end
        end
    endtask

    int idx_a;
    int idx_b;

    initial begin
        rst     = 1'b0;
        sensors = 8'hFF;
`ifdef EMERGENCY_PREEMPT_EN
        emg_req = 4'b0000;
`endif
        // Sequence A: idle, all congested, mixed, alternating, single lane, drain, start lane 2
        add(8'h00, 3, 4'b0000, 4'b0000, 1'b0);
        for (int l = 1; l <= 4; l++) add_lane(8'hFF, l, LONG);
        add_lane(8'h77, 1, LONG);
        add_lane(8'h77, 2, SLOT);
        add_lane(8'h77, 3, LONG);
        add_lane(8'h77, 4, SLOT);
        add_lane(8'h77, 1, LONG);
        add_lane(8'h41, 4, SLOT);
        add_lane(8'h41, 1, SLOT);
        add_lane(8'h41, 4, SLOT);
        add_lane(8'h01, 1, SLOT);
        add_lane(8'h01, 1, SLOT);
        add(8'h00, 3, 4'b0000, 4'b0000, 1'b0);
        add(8'hFF, 3, 4'b0010, 4'b0000, 1'b1);
        idx_a = vecs.size();
        // Sequence B: restart after reset
`ifdef EMERGENCY_PREEMPT_EN
        add(8'hFF, 2, 4'b0001, 4'b0000, 1'b1);
        add(8'hFF, YEL, 4'b0000, 4'b0001, 1'b1);
        add(8'hFF, AR, 4'b0000, 4'b0000, 1'b1);
        add(8'hFF, 8, 4'b0100, 4'b0000, 1'b1);
        add(8'hFF, YEL, 4'b0000, 4'b0100, 1'b1);
        add(8'hFF, AR, 4'b0000, 4'b0000, 1'b1);
        add(8'hFF, LONG, 4'b1000, 4'b0000, 1'b1);
`else
        add_lane(8'hFF, 1, LONG);
        add(8'hFF, LONG, 4'b0010, 4'b0000, 1'b1);
`endif
        idx_b = vecs.size();

        #2;
        check("reset_async", {green, yellow, busy}, 9'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_held", {green, yellow, busy}, 9'b0);
        end
        rst     = 1'b1;
        sensors = 8'h00;
        run(0, idx_a);

        // Mid-green reset abandons the phase immediately
        rst = 1'b0;
        #1;
        check("reset_mid_green", {green, yellow, busy}, 9'b0);
        @(posedge clk);
        #1;
        check("reset_mid_held", {green, yellow, busy}, 9'b0);
        rst = 1'b1;

`ifdef EMERGENCY_PREEMPT_EN
        run(idx_a, idx_a + 1);
        emg_req = 4'b0100;
        run(idx_a + 1, idx_a + 4);
        emg_req = 4'b0000;
        run(idx_a + 4, idx_b);
`else
        run(idx_a, idx_b);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
